print_tx: RTL and testbench

- Transmit-side counterpart of the serial debug unit's console input path.
- On a req/ack request from the debug controller, emits either one raw byte or a 32-bit word as ASCII hex, optionally followed by CR LF.
- Output goes to the UART transmitter over a byte-wide vld/rdy handshake.
- Sits between the debug command FSM and the UART TX core.

---
 rtl/print_tx.sv | 175 +++++++++++++++++
 tb/tb_print_tx.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/print_tx.sv
// print_tx: transmit side of the serial debug console.
// A request from the debug controller prints either one raw byte or a 32-bit
// word as eight uppercase ASCII hex characters (MSB nibble first), optionally
// followed by CR LF. Characters leave over a byte-wide vld/rdy handshake to
// the UART TX core. The outputs come directly from flops.
module print_tx #(
    parameter int unsigned NEWLINE = 1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_tx,
    input  logic        type_tx,
    input  logic [31:0] dout_tx,
    output logic        ack_tx,
    output logic        busy_tx,
    output logic [7:0]  d_tx,
    output logic        vld_tx,
    input  logic        rdy_tx
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Uppercase ASCII hex digit for one nibble.
    function automatic logic [7:0] hex_char(input logic [3:0] nib);
        logic [7:0] c;
        if (nib < 4'd10) begin
            c = 8'h30 + {4'h0, nib};
        end else begin
            c = 8'h41 + ({4'h0, nib} - 8'd10);
        end
        return c;
    endfunction

    // Character number idx of a job; byte jobs only ever use idx 0.
    function automatic logic [7:0] char_at(input logic [31:0] data,
                                           input logic        is_word,
                                           input logic [3:0]  idx);
        logic [7:0] c;
        if (!is_word) begin
            c = data[7:0];
        end else begin
            case (idx)
                4'd0:    c = hex_char(data[31:28]);
                4'd1:    c = hex_char(data[27:24]);
                4'd2:    c = hex_char(data[23:20]);
                4'd3:    c = hex_char(data[19:16]);
                4'd4:    c = hex_char(data[15:12]);
                4'd5:    c = hex_char(data[11:8]);
                4'd6:    c = hex_char(data[7:4]);
                4'd7:    c = hex_char(data[3:0]);
                4'd8:    c = 8'h0D;
                4'd9:    c = 8'h0A;
                default: c = 8'h00;
            endcase
        end
        return c;
    endfunction

    logic [1:0]  state_q, state_d;
    logic [31:0] data_q,  data_d;
    logic        type_q,  type_d;
    logic [3:0]  cnt_q,   cnt_d;
    logic [7:0]  d_tx_q,  d_tx_d;
    logic        vld_q,   vld_d;
    logic        ack_q,   ack_d;
    logic        busy_q,  busy_d;
    logic [3:0]  last_idx_s;
    logic        xfer_s;

    // Index of the final character of the captured job.
    always_comb begin
        last_idx_s = 4'd0;
        if (type_q) begin
            if (NEWLINE != 0) begin
                last_idx_s = 4'd9;
            end else begin
                last_idx_s = 4'd7;
            end
        end else begin
            last_idx_s = 4'd0;
        end
    end

    // A character is handed to the UART on any edge with vld and rdy both high.
    always_comb begin
        xfer_s = vld_q & rdy_tx;
    end

    // Next-state logic: capture in IDLE, step through characters in SEND, ack in DONE.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        type_d  = type_q;
        cnt_d   = cnt_q;
        d_tx_d  = d_tx_q;
        vld_d   = vld_q;
        ack_d   = 1'b0;
        busy_d  = busy_q;
        case (state_q)
            ST_IDLE: begin
                if (req_tx) begin
                    state_d = ST_SEND;
                    data_d  = dout_tx;
                    type_d  = type_tx;
                    cnt_d   = 4'd0;
                    d_tx_d  = char_at(dout_tx, type_tx, 4'd0);
                    vld_d   = 1'b1;
                    busy_d  = 1'b1;
                end else begin
                    vld_d   = 1'b0;
                    busy_d  = 1'b0;
                end
            end
            ST_SEND: begin
                if (xfer_s) begin
                    if (cnt_q == last_idx_s) begin
                        vld_d   = 1'b0;
                        ack_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        cnt_d   = cnt_q + 4'd1;
                        d_tx_d  = char_at(data_q, type_q, cnt_q + 4'd1);
                    end
                end else begin
                    // Hold the presented character until the UART takes it.
                    vld_d   = vld_q;
                end
            end
            ST_DONE: begin
                ack_d   = 1'b0;
                busy_d  = 1'b0;
                vld_d   = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                vld_d   = 1'b0;
                ack_d   = 1'b0;
                busy_d  = 1'b0;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // State and output registers; reset abandons any job without an ack.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            data_q  <= 32'h0000_0000;
            type_q  <= 1'b0;
            cnt_q   <= 4'd0;
            d_tx_q  <= 8'h00;
            vld_q   <= 1'b0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            type_q  <= type_d;
            cnt_q   <= cnt_d;
            d_tx_q  <= d_tx_d;
            vld_q   <= vld_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
        end
    end

    assign ack_tx  = ack_q;
    assign busy_tx = busy_q;
    assign d_tx    = d_tx_q;
    assign vld_tx  = vld_q;

endmodule

// File: tb/tb_print_tx.sv
// Bench for print_tx: one instance with CR LF terminator, one without.
// Expected characters are queued when a job is requested and popped as the
// DUT hands each byte over.
module tb_print_tx;

    logic        clk;
    logic        rstn;
    logic        req1, req0;
    logic        type_tx;
    logic [31:0] dout_tx;
    logic        rdy_tx;
    logic        ack1, busy1, vld1;
    logic [7:0]  d1;
    logic        ack0, busy0, vld0;
    logic [7:0]  d0;

    int n_checks;
    int n_fail;
    logic [7:0] exp_q[$];

    print_tx #(.NEWLINE(1)) dut_nl (
        .clk(clk), .rstn(rstn), .req_tx(req1), .type_tx(type_tx),
        .dout_tx(dout_tx), .ack_tx(ack1), .busy_tx(busy1), .d_tx(d1),
        .vld_tx(vld1), .rdy_tx(rdy_tx)
    );

    print_tx #(.NEWLINE(0)) dut_raw (
        .clk(clk), .rstn(rstn), .req_tx(req0), .type_tx(type_tx),
        .dout_tx(dout_tx), .ack_tx(ack0), .busy_tx(busy0), .d_tx(d0),
        .vld_tx(vld0), .rdy_tx(rdy_tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] model_hex(input logic [3:0] n);
        logic [7:0] tbl [16];
        tbl = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37,
                8'h38, 8'h39, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46};
        return tbl[n];
    endfunction

    // Run one job on the selected instance and check every handed-over byte.
    task automatic do_job(input bit nl, input bit typ, input logic [31:0] data,
                          input bit bp, input bit disturb, input bit check_lat,
                          input string name);
        int         n_exp;
        int         xfers;
        bit         got_ack;
        bit         prev_stall;
        logic [7:0] prev_d;
        logic       v, a, b;
        logic [7:0] d;
        logic [7:0] e;
        exp_q.delete();
        if (!typ) begin
            exp_q.push_back(data[7:0]);
        end else begin
            for (int i = 0; i < 8; i++) exp_q.push_back(model_hex(data[31-4*i -: 4]));
            if (nl) begin
                exp_q.push_back(8'h0D);
                exp_q.push_back(8'h0A);
            end
        end
        n_exp = exp_q.size();
        @(negedge clk);
        dout_tx = data;
        type_tx = typ;
        rdy_tx  = 1'b1;
        if (nl) req1 = 1'b1; else req0 = 1'b1;
        @(posedge clk);
        #1;
        req1 = 1'b0;
        req0 = 1'b0;
        v = nl ? vld1 : vld0;
        b = nl ? busy1 : busy0;
        n_checks++;
        if (v !== 1'b1 || b !== 1'b1) begin
            n_fail++;
            $display("FAIL %s capture: vld=%b busy=%b, required vld=1 busy=1", name, v, b);
        end
        got_ack = 1'b0;
        xfers = 0;
        prev_stall = 1'b0;
        prev_d = 8'h00;
        for (int cyc = 0; cyc < 300 && !got_ack; cyc++) begin
            @(negedge clk);
            v = nl ? vld1 : vld0;
            a = nl ? ack1 : ack0;
            b = nl ? busy1 : busy0;
            d = nl ? d1 : d0;
            if (a === 1'b1) begin
                got_ack = 1'b1;
                n_checks++;
                if (xfers != n_exp || exp_q.size() != 0 || v !== 1'b0 || b !== 1'b1) begin
                    n_fail++;
                    $display("FAIL %s ack: xfers=%0d left=%0d vld=%b busy=%b, required xfers=%0d left=0 vld=0 busy=1",
                             name, xfers, exp_q.size(), v, b, n_exp);
                end
                if (check_lat) begin
                    n_checks++;
                    if (cyc != n_exp) begin
                        n_fail++;
                        $display("FAIL %s latency: ack after %0d cycles, required %0d", name, cyc, n_exp);
                    end
                end
            end else begin
                if (prev_stall) begin
                    n_checks++;
                    if (v !== 1'b1 || d !== prev_d) begin
                        n_fail++;
                        $display("FAIL %s stall: vld=%b d=%h, required vld=1 d=%h", name, v, d, prev_d);
                    end
                end
                rdy_tx = bp ? (((cyc / 2) % 2 == 0) ? 1'b1 : 1'b0) : 1'b1;
                if (disturb && cyc == 3) begin
                    dout_tx = 32'hDEAD_BEEF;
                    if (nl) req1 = 1'b1; else req0 = 1'b1;
                end
                if (disturb && cyc == 4) begin
                    req1 = 1'b0;
                    req0 = 1'b0;
                end
                if (v !== 1'b1) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL %s vld: vld=%b before ack, required 1", name, v);
                end else if (rdy_tx) begin
                    n_checks++;
                    xfers++;
                    prev_stall = 1'b0;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL %s extra char: d=%h, required none", name, d);
                    end else begin
                        e = exp_q.pop_front();
                        if (d !== e) begin
                            n_fail++;
                            $display("FAIL %s char %0d: d=%h, required %h", name, xfers - 1, d, e);
                        end
                    end
                end else begin
                    prev_stall = 1'b1;
                    prev_d = d;
                end
            end
        end
        req1 = 1'b0;
        req0 = 1'b0;
        rdy_tx = 1'b1;
        if (!got_ack) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s timeout: no ack, required ack", name);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            a = nl ? ack1 : ack0;
            b = nl ? busy1 : busy0;
            v = nl ? vld1 : vld0;
            n_checks++;
            if (a !== 1'b0 || b !== 1'b0 || v !== 1'b0) begin
                n_fail++;
                $display("FAIL %s idle after ack %0d: ack=%b busy=%b vld=%b, required 0 0 0", name, k, a, b, v);
            end
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        req1 = 1'b0;
        req0 = 1'b0;
        type_tx = 1'b0;
        dout_tx = 32'h0;
        rdy_tx = 1'b0;
        #3;
        n_checks++;
        if ({ack1, busy1, vld1, d1, ack0, busy0, vld0, d0} !== 22'h0) begin
            n_fail++;
            $display("FAIL reset: nl ack/busy/vld/d=%b%b%b/%h raw=%b%b%b/%h, required all 0",
                     ack1, busy1, vld1, d1, ack0, busy0, vld0, d0);
        end
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_byte();
        do_job(1'b1, 1'b0, 32'hFFFF_FF41, 1'b0, 1'b0, 1'b1, "byte");
    endtask

    task automatic test_word_newline();
        do_job(1'b1, 1'b1, 32'h1234_ABCD, 1'b0, 1'b0, 1'b1, "word_nl");
    endtask

    task automatic test_backpressure();
        do_job(1'b1, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b0, "backpressure");
    endtask

    task automatic test_ignored_req();
        do_job(1'b1, 1'b1, 32'h1357_9BDF, 1'b0, 1'b1, 1'b1, "ignored_req");
    endtask

    task automatic test_newline0();
        do_job(1'b0, 1'b1, 32'hF00D_CAFE, 1'b0, 1'b0, 1'b1, "word_raw");
    endtask

    task automatic test_back_to_back();
        do_job(1'b0, 1'b0, 32'h0000_00A5, 1'b0, 1'b0, 1'b1, "b2b_first");
        do_job(1'b0, 1'b1, 32'h0F1E_2D3C, 1'b0, 1'b0, 1'b1, "b2b_second");
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        dout_tx = 32'h89AB_CDEF;
        type_tx = 1'b1;
        rdy_tx = 1'b1;
        req1 = 1'b1;
        @(posedge clk);
        #1;
        req1 = 1'b0;
        repeat (4) @(negedge clk);
        n_checks++;
        if (vld1 !== 1'b1 || d1 !== 8'h42) begin
            n_fail++;
            $display("FAIL reset_mid before: vld=%b d=%h, required vld=1 d=42", vld1, d1);
        end
        rstn = 1'b0;
        #1;
        n_checks++;
        if (vld1 !== 1'b0 || busy1 !== 1'b0 || ack1 !== 1'b0 || d1 !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_mid async: vld=%b busy=%b ack=%b d=%h, required 0 0 0 00",
                     vld1, busy1, ack1, d1);
        end
        @(negedge clk);
        n_checks++;
        if (ack1 !== 1'b0 || vld1 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid held: ack=%b vld=%b, required 0 0", ack1, vld1);
        end
        rstn = 1'b1;
        @(negedge clk);
        do_job(1'b1, 1'b0, 32'h0000_000A, 1'b0, 1'b0, 1'b1, "after_reset");
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        test_reset();
        test_byte();
        test_word_newline();
        test_backpressure();
        test_ignored_req();
        test_newline0();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
